crc_bit_serializer: RTL

Upstream feeder for the serial CRC-32 stage. Accepts a byte stream with a valid/ready/last handshake and emits one data bit per clock, LSB first, with a per-bit valid. Emits a one-cycle CRC init pulse ahead of each frame and enforces a programmable inter-frame gap. `bit_out`/`bit_valid` connect directly to the CRC stage's `data_in`/`data_valid`, and `crc_init` drives its synchronous `res`.

---
 rtl/crc_pkg.sv | 19 +
 rtl/crc_bit_serializer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC-32 datapath: serializer state
// encoding, the CRC polynomial and default feeder geometry.
package crc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } ser_state_t;

  // CRC-32 generator in Koopman notation (implicit +1 term), i.e. 0x04C11DB7.
  localparam logic [31:0] CRC_POLY = 32'h82608EDB;

  localparam int DEFAULT_DATA_W   = 8;
  localparam int DEFAULT_GAP_BITS = 12;

endpackage

// File: rtl/crc_bit_serializer.sv
// Byte-to-bit feeder for the serial CRC-32 stage. Takes a valid/ready/last
// byte stream and emits one bit per clock, LSB first, framed by a CRC init
// pulse before the frame and a programmable idle gap after it.
module crc_bit_serializer
  import crc_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int GAP_BITS = DEFAULT_GAP_BITS
) (
  input  logic              clk,
  input  logic              res,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              crc_init,
  output logic              sof,
  output logic              eof,
  output logic              underrun
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_BITS);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  ser_state_t        state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              last_flag, last_nxt;
  logic              first, first_nxt;
  logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic              under_nxt;
  logic              accept;

  // s_ready is a registered output, so the handshake never sees s_valid combinationally.
  assign accept = s_valid && s_ready;

  // Next-state computation for the framing FSM, shift register and counters.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    last_nxt  = last_flag;
    first_nxt = first;
    cnt_nxt   = bit_cnt;
    gap_nxt   = gap_cnt;
    under_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = INIT;
          shreg_nxt = s_data;
          last_nxt  = s_last;
        end
      end
      INIT: begin
        state_nxt = SHIFT;
        cnt_nxt   = '0;
        first_nxt = 1'b1;
      end
      SHIFT: begin
        if (bit_cnt == LAST_CNT) begin
          if (last_flag) begin
            if (GAP_BITS > 0) begin
              state_nxt = GAP;
              gap_nxt   = GAP_LOAD;
            end else begin
              state_nxt = IDLE;
            end
          end else if (accept) begin
            shreg_nxt = s_data;
            last_nxt  = s_last;
            cnt_nxt   = '0;
            first_nxt = 1'b0;
          end else begin
            state_nxt = HOLD;
            under_nxt = 1'b1;
          end
        end else begin
          shreg_nxt = shreg >> 1;
          cnt_nxt   = bit_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (accept) begin
          state_nxt = SHIFT;
          shreg_nxt = s_data;
          last_nxt  = s_last;
          cnt_nxt   = '0;
          first_nxt = 1'b0;
        end
      end
      GAP: begin
        if (gap_cnt <= GAP_ONE) begin
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; outputs are registered from next-state so ready stays low during reset.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= IDLE;
      shreg     <= '0;
      last_flag <= 1'b0;
      first     <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      s_ready   <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      crc_init  <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      last_flag <= last_nxt;
      first     <= first_nxt;
      bit_cnt   <= cnt_nxt;
      gap_cnt   <= gap_nxt;
      s_ready   <= (state_nxt == IDLE) || (state_nxt == HOLD) ||
                   ((state_nxt == SHIFT) && (cnt_nxt == LAST_CNT) && !last_nxt);
      bit_out   <= shreg_nxt[0];
      bit_valid <= (state_nxt == SHIFT);
      crc_init  <= (state_nxt == INIT);
      sof       <= (state_nxt == SHIFT) && first_nxt && (cnt_nxt == '0);
      eof       <= (state_nxt == SHIFT) && last_nxt && (cnt_nxt == LAST_CNT);
      underrun  <= under_nxt;
    end
  end

endmodule
